// File: rtl/operand_mux_pipe_pkg.sv
// Shared definitions for operand_mux_pipe: occupancy encoding, legal source
// count range and the select-width helpers used to size ports.
package operand_mux_pipe_pkg;

  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Out-of-range source counts are pulled into the legal range so the
  // select width never collapses to zero bits.
  function automatic int sel_w(input int num_in);
    int n;
    n = (num_in < NUM_IN_MIN) ? NUM_IN_MIN :
        (num_in > NUM_IN_MAX) ? NUM_IN_MAX : num_in;
    return clog2(n);
  endfunction

endpackage

// File: rtl/operand_mux_pipe_skid_reg.sv
// Generic 2-entry skid buffer: main register drives the output, skid entry
// absorbs one extra beat so in_ready can be registered without losing throughput.
module operand_mux_pipe_skid_reg
  import operand_mux_pipe_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  occ_e          r_state;
  occ_e          w_state_next;
  logic          r_in_ready;
  logic [DW-1:0] r_main;
  logic [DW-1:0] r_skid;
  logic          w_accept;
  logic          w_retire;
  logic          w_load_main_in;
  logic          w_load_main_skid;
  logic          w_load_skid;

  assign w_accept = in_valid && r_in_ready && !flush;
  assign w_retire = (r_state != OCC_EMPTY) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= OCC_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != OCC_TWO);
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: if (w_accept) w_state_next = OCC_ONE;
        OCC_ONE: begin
          if (w_accept && !w_retire)      w_state_next = OCC_TWO;
          else if (w_retire && !w_accept) w_state_next = OCC_EMPTY;
        end
        OCC_TWO:   if (w_retire) w_state_next = OCC_ONE;
        default:   w_state_next = OCC_EMPTY;
      endcase
    end
  end

  // Loads are suppressed during flush so out_data keeps its last value.
  always_comb begin
    out_valid        = (r_state != OCC_EMPTY);
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (!flush) begin
      case (r_state)
        OCC_EMPTY: w_load_main_in = w_accept;
        OCC_ONE: begin
          w_load_main_in = w_accept && w_retire;
          w_load_skid    = w_accept && !w_retire;
        end
        OCC_TWO:   w_load_main_skid = w_retire;
        default:   w_load_main_in = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in)        r_main <= in_data;
      else if (w_load_main_skid) r_main <= r_skid;
      if (w_load_skid)           r_skid <= in_data;
    end
  end

  assign in_ready = r_in_ready;
  assign out_data = r_main;

endmodule

// File: rtl/operand_mux_pipe.sv
// Registered NUM_IN:1 operand selector with valid/ready output, flush and a
// sticky out-of-range select flag.
module operand_mux_pipe
  import operand_mux_pipe_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               NUM_IN      = 4,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [sel_w(NUM_IN)-1:0]  sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  output logic [WIDTH-1:0]          out_data,
  output logic [sel_w(NUM_IN)-1:0]  out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err,
  input  logic                      err_clr
);

  localparam int SEL_W = sel_w(NUM_IN);
  localparam int NSLOT = 1 << SEL_W;
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

  logic [WIDTH-1:0] w_src [NSLOT];
  logic [WIDTH-1:0] w_sel_data;
  logic             w_oor;
  logic             w_accept;
  logic             r_sel_err;

  // Unused select codes map to DEFAULT_VAL, so the mux is a plain index.
  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_src
    if (gi < NUM_IN) begin : g_real
      assign w_src[gi] = in_data[gi*WIDTH +: WIDTH];
    end else begin : g_default
      assign w_src[gi] = DEFAULT_VAL;
    end
  end

  assign w_sel_data = w_src[sel];
  assign w_oor      = ({1'b0, sel} >= NUM_IN_W);
  assign w_accept   = in_valid && in_ready && !flush;

  operand_mux_pipe_skid_reg #(
    .DW(WIDTH + SEL_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_data  ({w_sel_data, sel}),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data ({out_data, out_sel}),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Setting beats clearing when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                    r_sel_err <= 1'b0;
    else if (w_accept && w_oor) r_sel_err <= 1'b1;
    else if (err_clr)           r_sel_err <= 1'b0;
  end

  assign sel_err = r_sel_err;

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Bench for operand_mux_pipe: three configurations (4x8, 3x8 with default,
// 16x32 soak) driven from tables, hand sequences and a queue model.
module tb_operand_mux_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: NUM_IN=4, WIDTH=8
  logic [31:0] a_in_data;
  logic [1:0]  a_sel, a_os;
  logic [7:0]  a_od;
  logic        a_iv, a_ir, a_fl, a_ov, a_or, a_err, a_clr;
  // Instance B: NUM_IN=3, WIDTH=8, DEFAULT_VAL=0xA5
  logic [23:0] b_in_data;
  logic [1:0]  b_sel, b_os;
  logic [7:0]  b_od;
  logic        b_iv, b_ir, b_fl, b_ov, b_or, b_err, b_clr;
  // Instance C: NUM_IN=16, WIDTH=32
  logic [511:0] c_in_data;
  logic [3:0]   c_sel, c_os;
  logic [31:0]  c_od;
  logic         c_iv, c_ir, c_fl, c_ov, c_or, c_err, c_clr;

  operand_mux_pipe #(.WIDTH(8), .NUM_IN(4), .DEFAULT_VAL(8'h00)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .sel(a_sel), .in_valid(a_iv),
    .in_ready(a_ir), .flush(a_fl), .out_data(a_od), .out_sel(a_os),
    .out_valid(a_ov), .out_ready(a_or), .sel_err(a_err), .err_clr(a_clr));

  operand_mux_pipe #(.WIDTH(8), .NUM_IN(3), .DEFAULT_VAL(8'hA5)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .sel(b_sel), .in_valid(b_iv),
    .in_ready(b_ir), .flush(b_fl), .out_data(b_od), .out_sel(b_os),
    .out_valid(b_ov), .out_ready(b_or), .sel_err(b_err), .err_clr(b_clr));

  operand_mux_pipe #(.WIDTH(32), .NUM_IN(16), .DEFAULT_VAL(32'h0)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .sel(c_sel), .in_valid(c_iv),
    .in_ready(c_ir), .flush(c_fl), .out_data(c_od), .out_sel(c_os),
    .out_valid(c_ov), .out_ready(c_or), .sel_err(c_err), .err_clr(c_clr));

  typedef struct {
    int         dut;
    logic       iv;
    logic [3:0] sel;
    logic       ordy;
    logic       fl;
    logic       clr;
    logic       e_ov;
    logic [7:0] e_data;
    logic [3:0] e_sel;
    logic       e_ir;
    logic       e_err;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
  } item_t;

  vec_t  tbl[$];
  item_t model_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ab();
    a_iv = 1'b0; a_fl = 1'b0; a_clr = 1'b0; a_or = 1'b1; a_sel = 2'd0;
    b_iv = 1'b0; b_fl = 1'b0; b_clr = 1'b0; b_or = 1'b1; b_sel = 2'd0;
  endtask

  initial begin
    logic       g_ov, g_ir, g_err;
    logic [7:0] g_d;
    logic [3:0] g_s;

    a_in_data = 32'h44332211;
    b_in_data = 24'h332211;
    c_in_data = '0;
    c_sel = 4'd0; c_iv = 1'b1; c_fl = 1'b0; c_or = 1'b0; c_clr = 1'b0;
    idle_ab();
    a_iv = 1'b1; b_iv = 1'b1; a_or = 1'b0; b_or = 1'b0;

    // Reset held two cycles while upstream keeps offering.
    rst = 1'b1;
    tick();
    tick();
    chk("reset.a.out_valid", a_ov, 1'b0);
    chk("reset.a.in_ready",  a_ir, 1'b1);
    chk("reset.a.sel_err",   a_err, 1'b0);
    chk("reset.a.out_data",  a_od, 8'h00);
    chk("reset.b.out_valid", b_ov, 1'b0);
    chk("reset.b.sel_err",   b_err, 1'b0);
    chk("reset.c.out_valid", c_ov, 1'b0);
    chk("reset.c.out_sel",   c_os, 4'd0);
    rst = 1'b0;
    c_iv = 1'b0;
    idle_ab();

    // dut iv sel or fl clr | ov data sel ir err
    tbl.push_back('{0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 4'd0, 1'b1, 1'b0});
    tbl.push_back('{0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 4'd1, 1'b1, 1'b0});
    tbl.push_back('{0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 4'd2, 1'b1, 1'b0});
    tbl.push_back('{0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 4'd3, 1'b1, 1'b0});
    tbl.push_back('{0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 4'd3, 1'b1, 1'b0});
    tbl.push_back('{0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 4'd2, 1'b1, 1'b0});
    tbl.push_back('{0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 4'd2, 1'b0, 1'b0});
    tbl.push_back('{0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 4'd2, 1'b0, 1'b0});
    tbl.push_back('{0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 4'd1, 1'b1, 1'b0});
    tbl.push_back('{0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 4'd1, 1'b1, 1'b0});
    tbl.push_back('{1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 4'd3, 1'b1, 1'b1});
    tbl.push_back('{1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 4'd3, 1'b1, 1'b0});
    tbl.push_back('{1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 4'd3, 1'b1, 1'b1});
    tbl.push_back('{1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd3, 1'b1, 1'b1});
    tbl.push_back('{1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 4'd2, 1'b1, 1'b1});
    tbl.push_back('{1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 4'd2, 1'b1, 1'b0});
    tbl.push_back('{1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 4'd2, 1'b1, 1'b0});
    tbl.push_back('{1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 4'd2, 1'b1, 1'b0});

    foreach (tbl[i]) begin
      idle_ab();
      if (tbl[i].dut == 0) begin
        a_iv = tbl[i].iv; a_sel = tbl[i].sel[1:0]; a_or = tbl[i].ordy;
        a_fl = tbl[i].fl; a_clr = tbl[i].clr;
      end else begin
        b_iv = tbl[i].iv; b_sel = tbl[i].sel[1:0]; b_or = tbl[i].ordy;
        b_fl = tbl[i].fl; b_clr = tbl[i].clr;
      end
      tick();
      if (tbl[i].dut == 0) begin
        g_ov = a_ov; g_d = a_od; g_s = {2'b00, a_os}; g_ir = a_ir; g_err = a_err;
      end else begin
        g_ov = b_ov; g_d = b_od; g_s = {2'b00, b_os}; g_ir = b_ir; g_err = b_err;
      end
      chk($sformatf("vec%0d.out_valid", i), g_ov,  tbl[i].e_ov);
      chk($sformatf("vec%0d.out_data", i),  g_d,   tbl[i].e_data);
      chk($sformatf("vec%0d.out_sel", i),   g_s,   tbl[i].e_sel);
      chk($sformatf("vec%0d.in_ready", i),  g_ir,  tbl[i].e_ir);
      chk($sformatf("vec%0d.sel_err", i),   g_err, tbl[i].e_err);
    end

    // Flush while full, with a new offer in the same cycle.
    idle_ab();
    a_or = 1'b0; a_iv = 1'b1; a_sel = 2'd2;
    tick();
    a_sel = 2'd1;
    tick();
    chk("flush.pre_in_ready", a_ir, 1'b0);
    a_fl = 1'b1; a_sel = 2'd0;
    tick();
    chk("flush.out_valid", a_ov, 1'b0);
    chk("flush.in_ready",  a_ir, 1'b1);
    chk("flush.out_data_kept", a_od, 8'h33);
    a_fl = 1'b0; a_iv = 1'b0; a_or = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("flush.dropped%0d", k), a_ov, 1'b0);
    end

    // Reset in the middle of traffic.
    a_iv = 1'b1; a_sel = 2'd3; a_or = 1'b0;
    tick();
    chk("midrst.pre_data", a_od, 8'h44);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.out_valid", a_ov, 1'b0);
    chk("midrst.out_data",  a_od, 8'h00);
    chk("midrst.in_ready",  a_ir, 1'b1);
    idle_ab();

    // Random soak against a queue model of the two-entry FIFO.
    model_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic  exp_ready, do_acc, do_ret;
      item_t it;
      for (int k = 0; k < 16; k++) c_in_data[k*32 +: 32] = $urandom;
      c_sel = 4'($urandom_range(0, 15));
      c_iv  = ($urandom_range(0, 3) != 0);
      c_or  = ($urandom_range(0, 2) != 0);
      c_fl  = ($urandom_range(0, 19) == 0);
      c_clr = ($urandom_range(0, 7) == 0);
      exp_ready = (model_q.size() < 2);
      do_ret = (model_q.size() > 0) && c_or;
      do_acc = c_iv && exp_ready && !c_fl;
      it.d = c_in_data[int'(c_sel)*32 +: 32];
      it.s = c_sel;
      tick();
      if (do_ret) void'(model_q.pop_front());
      if (c_fl) model_q.delete();
      else if (do_acc) model_q.push_back(it);
      chk($sformatf("soak%0d.out_valid", cyc), c_ov, model_q.size() > 0);
      chk($sformatf("soak%0d.in_ready", cyc),  c_ir, model_q.size() < 2);
      chk($sformatf("soak%0d.sel_err", cyc),   c_err, 1'b0);
      if (model_q.size() > 0) begin
        chk($sformatf("soak%0d.out_data", cyc), c_od, model_q[0].d);
        chk($sformatf("soak%0d.out_sel", cyc),  c_os, model_q[0].s);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
